// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - bit-serial adder/subtractor built around a single full-adder cell

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [WIDTH-1:0] sa, sb;
    logic [CW-1:0]   cnt;
    logic            c;
    logic            fa_s, fa_co;
    logic            load, shift, last;

    full_adder u_fa (
        .a  (sa[0]),
        .b  (sb[0]),
        .ci (c),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The carry flop is the carry-in of the bit in flight, so on the MSB edge
    // it is exactly the value needed for the overflow XOR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sa       <= '0;
            sb       <= '0;
            c        <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            if (load) begin
                sa       <= a;
                sb       <= sub ? ~b : b;
                c        <= sub;
                cnt      <= '0;
                result   <= '0;
                cout     <= 1'b0;
                overflow <= 1'b0;
            end else if (shift) begin
                result <= {fa_s, result[WIDTH-1:1]};
                sa     <= sa >> 1;
                sb     <= sb >> 1;
                c      <= fa_co;
                cnt    <= cnt + CW'(1);
                if (last) begin
                    cout     <= fa_co;
                    overflow <= c ^ fa_co;
                end
            end
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_add_sub.sv
// tb/tb_serial_add_sub.sv - scoreboard bench for serial_add_sub with directed vectors

module tb_serial_add_sub;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a, b;
    logic             busy, done, cout, overflow;
    logic [WIDTH-1:0] result;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             co;
        logic             ov;
        int               cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    serial_add_sub #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got result=0x%0h at cycle %0d, expected no done", result, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (result !== e.res || cout !== e.co || overflow !== e.ov || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL done_result: got res=0x%0h cout=%0b ovf=%0b cyc=%0d expected res=0x%0h cout=%0b ovf=%0b cyc=%0d",
                             result, cout, overflow, cyc, e.res, e.co, e.ov, e.cyc);
                end
            end
        end
    end

    task automatic push_exp(input logic [WIDTH-1:0] r, input logic co, input logic ov, input int at);
        exp_t e;
        e.res = r; e.co = co; e.ov = ov; e.cyc = at;
        sb_q.push_back(e);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drained"}, sb_q.size(), 0);
        sb_q.delete();
        @(negedge clk);
    endtask

    // Issue one operation from a negedge; done is due 1+WIDTH edges later.
    task automatic do_op(input string name, input logic s, input logic [WIDTH-1:0] av,
                         input logic [WIDTH-1:0] bv, input logic [WIDTH-1:0] r,
                         input logic co, input logic ov);
        sub = s; a = av; b = bv; start = 1'b1;
        push_exp(r, co, ov, cyc + 1 + WIDTH);
        @(negedge clk);
        start = 1'b0; a = '0; b = '0; sub = 1'b0;
        chk({name, "_busy_first"}, busy, 1);
        repeat (WIDTH - 1) @(negedge clk);
        chk({name, "_busy_last"}, busy, 1);
        wait_idle(name, 4);
        chk({name, "_idle_after"}, {busy, done}, 0);
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("add_3c_15", 1'b0, 8'h3C, 8'h15, 8'h51, 1'b0, 1'b0);
        do_op("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
        do_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        chk("hold_result", result, 8'h00);
        chk("hold_cout", cout, 1);
        do_op("sub_05_07", 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
        do_op("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);

        // Starts during SHIFT and DONE must be ignored.
        sub = 1'b0; a = 8'h10; b = 8'h20; start = 1'b1;
        push_exp(8'h30, 1'b0, 1'b0, cyc + 1 + WIDTH);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'hFF; b = 8'hFF; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int n = 0;
            while (done !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("ignore_done_seen", done, 1);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0; sub = 1'b0;
        repeat (12) @(negedge clk);
        chk("ignore_no_extra", sb_q.size(), 0);
        chk("ignore_final_result", result, 8'h30);

        // Reset mid-shift discards the operation.
        a = 8'hAA; b = 8'h55; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_result", result, 0);
        chk("midrst_flags", {cout, overflow}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op("after_rst", 1'b0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);

        // Continuous start: one accepted operation every WIDTH+2 edges.
        a = 8'h01; b = 8'h01; sub = 1'b0; start = 1'b1;
        for (int i = 0; i < 3; i++) push_exp(8'h02, 1'b0, 1'b0, cyc + 1 + WIDTH + i * (WIDTH + 2));
        repeat (30) @(negedge clk);
        start = 1'b0;
        wait_idle("held_start", 15);
        repeat (12) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
